// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM pipeline register with stall, flush and bubble insertion
// Multiply-accumulate feedback (hilo_temp_o / cnt_o) is built only when EX_MEM_MADD_EN is defined.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
`ifdef EX_MEM_MADD_EN
  input  logic [2*DATA_W-1:0]   ex_hilo_temp,
  input  logic [CNT_W-1:0]      ex_cnt,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o,
`endif
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic                  mem_valid
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic [ALUOP_W-1:0]    aluop;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     reg2;
  } slot_t;

  slot_t slot_q;
  slot_t slot_d;
  slot_t ex_slot;

  always_comb begin
    ex_slot = '{valid:    1'b1,
                wd:       ex_wd,
                wreg:     ex_wreg,
                wdata:    ex_wdata,
                whilo:    ex_whilo,
                hi:       ex_hi,
                lo:       ex_lo,
                aluop:    ex_aluop,
                mem_addr: ex_mem_addr,
                reg2:     ex_reg2};
  end

  // Priority: flush, advance, bubble, hold. An all-zero slot is the NOP bubble.
  always_comb begin
    slot_d = slot_q;
    if (flush) begin
      slot_d = '0;
    end else if (!stall_ex) begin
      slot_d = ex_slot;
    end else if (!stall_mem) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign mem_valid    = slot_q.valid;
  assign mem_wd       = slot_q.wd;
  assign mem_wreg     = slot_q.wreg;
  assign mem_wdata    = slot_q.wdata;
  assign mem_whilo    = slot_q.whilo;
  assign mem_hi       = slot_q.hi;
  assign mem_lo       = slot_q.lo;
  assign mem_aluop    = slot_q.aluop;
  assign mem_mem_addr = slot_q.mem_addr;
  assign mem_reg2     = slot_q.reg2;

`ifdef EX_MEM_MADD_EN
  logic [2*DATA_W-1:0] hilo_temp_q;
  logic [2*DATA_W-1:0] hilo_temp_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                capture_fb;

  // EX only needs its intermediate back while it is stalled and not being flushed.
  assign capture_fb = !flush && stall_ex;

  always_comb begin
    hilo_temp_d = '0;
    cnt_d       = '0;
    if (capture_fb) begin
      hilo_temp_d = ex_hilo_temp;
      cnt_d       = ex_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_temp_q <= '0;
      cnt_q       <= '0;
    end else begin
      hilo_temp_q <= hilo_temp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;
`else
  // Keeps CNT_W referenced when the feedback storage is compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage
// Table vectors, randomized run against a behavioural model, and async reset sequence; honours EX_MEM_MADD_EN.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, stall_ex, stall_mem;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cnt;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, mem_valid;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
`ifdef EX_MEM_MADD_EN
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
`endif

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
`ifdef EX_MEM_MADD_EN
    .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o),
`endif
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_valid(mem_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected architectural view of the MEM slot plus the feedback returned to EX.
  typedef struct {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic [7:0]  aluop;
    logic [31:0] addr, reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } exp_t;

  exp_t m;

  typedef struct {
    logic        f, sx, sm;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [63:0] hin;
    logic [1:0]  cin;
    logic        e_valid;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [7:0]  e_aluop;
    logic [31:0] e_addr;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic f, sx, sm, input logic [4:0] wd, input logic wreg,
                              input logic [31:0] wdata, input logic [7:0] aluop, input logic [31:0] addr,
                              input logic [63:0] hin, input logic [1:0] cin,
                              input logic ev, input logic [4:0] ewd, input logic ewreg,
                              input logic [31:0] ewdata, input logic [7:0] ealuop, input logic [31:0] eaddr,
                              input logic [63:0] ehilo, input logic [1:0] ecnt);
    vec_t v;
    v.f = f; v.sx = sx; v.sm = sm; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
    v.aluop = aluop; v.addr = addr; v.hin = hin; v.cin = cin;
    v.e_valid = ev; v.e_wd = ewd; v.e_wreg = ewreg; v.e_wdata = ewdata;
    v.e_aluop = ealuop; v.e_addr = eaddr; v.e_hilo = ehilo; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t cleared();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // Reference model: applies the stage rules to the inputs about to be clocked in.
  task automatic model_step();
    if (flush) begin
      m = cleared();
    end else if (!stall_ex) begin
      m.valid = 1'b1; m.wd = ex_wd; m.wreg = ex_wreg; m.wdata = ex_wdata;
      m.whilo = ex_whilo; m.hi = ex_hi; m.lo = ex_lo; m.aluop = ex_aluop;
      m.addr = ex_mem_addr; m.reg2 = ex_reg2; m.hilo = '0; m.cnt = '0;
    end else begin
      if (!stall_mem) m = cleared();
      m.hilo = ex_hilo_temp;
      m.cnt  = ex_cnt;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 64'(mem_valid),    64'(m.valid));
    chk({tag, ".wd"},    64'(mem_wd),       64'(m.wd));
    chk({tag, ".wreg"},  64'(mem_wreg),     64'(m.wreg));
    chk({tag, ".wdata"}, 64'(mem_wdata),    64'(m.wdata));
    chk({tag, ".whilo"}, 64'(mem_whilo),    64'(m.whilo));
    chk({tag, ".hi"},    64'(mem_hi),       64'(m.hi));
    chk({tag, ".lo"},    64'(mem_lo),       64'(m.lo));
    chk({tag, ".aluop"}, 64'(mem_aluop),    64'(m.aluop));
    chk({tag, ".addr"},  64'(mem_mem_addr), 64'(m.addr));
    chk({tag, ".reg2"},  64'(mem_reg2),     64'(m.reg2));
`ifdef EX_MEM_MADD_EN
    chk({tag, ".hilo"},  hilo_temp_o,       m.hilo);
    chk({tag, ".cnt"},   64'(cnt_o),        64'(m.cnt));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_zero();
    flush = 0; stall_ex = 0; stall_mem = 0;
    ex_wd = '0; ex_wreg = 0; ex_wdata = '0; ex_whilo = 0; ex_hi = '0; ex_lo = '0;
    ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0; ex_hilo_temp = '0; ex_cnt = '0;
  endtask

  vec_t tbl[11];

  initial begin
    rst = 1'b1;
    drive_zero();
    m = cleared();
    step();
    step();
    chk_all("reset");
    rst = 1'b0;

    tbl[0]  = mk(0,0,0, 5'd5, 1, 32'hDEADBEEF, 8'h23, 32'h100, 64'h55, 2'd3,
                 1, 5'd5, 1, 32'hDEADBEEF, 8'h23, 32'h100, 64'h0, 2'd0);
    tbl[1]  = mk(0,1,0, 5'd9, 1, 32'h1111, 8'h11, 32'h44, 64'h0000000100000002, 2'd1,
                 0, 5'd0, 0, 32'h0, 8'h0, 32'h0, 64'h0000000100000002, 2'd1);
    tbl[2]  = mk(0,0,0, 5'd7, 1, 32'hA5, 8'h2B, 32'h200, 64'h0, 2'd0,
                 1, 5'd7, 1, 32'hA5, 8'h2B, 32'h200, 64'h0, 2'd0);
    tbl[3]  = mk(0,1,1, 5'd3, 0, 32'hB0, 8'h01, 32'h300, 64'h33, 2'd2,
                 1, 5'd7, 1, 32'hA5, 8'h2B, 32'h200, 64'h33, 2'd2);
    tbl[4]  = mk(0,1,1, 5'd4, 1, 32'hB1, 8'h02, 32'h304, 64'h34, 2'd3,
                 1, 5'd7, 1, 32'hA5, 8'h2B, 32'h200, 64'h34, 2'd3);
    tbl[5]  = mk(0,1,1, 5'd6, 1, 32'hB2, 8'h03, 32'h308, 64'h35, 2'd1,
                 1, 5'd7, 1, 32'hA5, 8'h2B, 32'h200, 64'h35, 2'd1);
    tbl[6]  = mk(1,1,1, 5'd8, 1, 32'hC0, 8'h04, 32'h400, 64'h44, 2'd3,
                 0, 5'd0, 0, 32'h0, 8'h0, 32'h0, 64'h0, 2'd0);
    tbl[7]  = mk(0,0,0, 5'd31, 0, 32'hFFFFFFFF, 8'hFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 2'd3,
                 1, 5'd31, 0, 32'hFFFFFFFF, 8'hFF, 32'hFFFFFFFF, 64'h0, 2'd0);
    tbl[8]  = mk(1,0,0, 5'd2, 1, 32'hD0, 8'h05, 32'h500, 64'h66, 2'd2,
                 0, 5'd0, 0, 32'h0, 8'h0, 32'h0, 64'h0, 2'd0);
    tbl[9]  = mk(0,1,0, 5'd1, 1, 32'hE0, 8'h06, 32'h600, 64'h77, 2'd2,
                 0, 5'd0, 0, 32'h0, 8'h0, 32'h0, 64'h77, 2'd2);
    tbl[10] = mk(0,1,1, 5'd1, 1, 32'hE1, 8'h07, 32'h604, 64'h88, 2'd1,
                 0, 5'd0, 0, 32'h0, 8'h0, 32'h0, 64'h88, 2'd1);

    for (int i = 0; i < 11; i++) begin
      drive_zero();
      flush = tbl[i].f; stall_ex = tbl[i].sx; stall_mem = tbl[i].sm;
      ex_wd = tbl[i].wd; ex_wreg = tbl[i].wreg; ex_wdata = tbl[i].wdata;
      ex_aluop = tbl[i].aluop; ex_mem_addr = tbl[i].addr;
      ex_hilo_temp = tbl[i].hin; ex_cnt = tbl[i].cin;
      model_step();
      step();
      chk($sformatf("vec%0d.valid", i), 64'(mem_valid),    64'(tbl[i].e_valid));
      chk($sformatf("vec%0d.wd", i),    64'(mem_wd),       64'(tbl[i].e_wd));
      chk($sformatf("vec%0d.wreg", i),  64'(mem_wreg),     64'(tbl[i].e_wreg));
      chk($sformatf("vec%0d.wdata", i), 64'(mem_wdata),    64'(tbl[i].e_wdata));
      chk($sformatf("vec%0d.aluop", i), 64'(mem_aluop),    64'(tbl[i].e_aluop));
      chk($sformatf("vec%0d.addr", i),  64'(mem_mem_addr), 64'(tbl[i].e_addr));
`ifdef EX_MEM_MADD_EN
      chk($sformatf("vec%0d.hilo", i),  hilo_temp_o,       tbl[i].e_hilo);
      chk($sformatf("vec%0d.cnt", i),   64'(cnt_o),        64'(tbl[i].e_cnt));
`endif
    end

    for (int i = 0; i < 400; i++) begin
      flush     = ($urandom_range(0, 9) == 0);
      stall_ex  = ($urandom_range(0, 2) == 0);
      stall_mem = stall_ex ? 1'($urandom_range(0, 1)) : 1'b0;
      ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
      ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
      ex_aluop = 8'($urandom); ex_mem_addr = $urandom; ex_reg2 = $urandom;
      ex_hilo_temp = {$urandom, $urandom}; ex_cnt = 2'($urandom);
      model_step();
      step();
      chk_all($sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a cycle, with feedback non-zero.
    drive_zero();
    ex_wd = 5'd12; ex_wreg = 1; ex_wdata = 32'h1234; ex_aluop = 8'h2B;
    model_step();
    step();
    chk_all("pre_rst_adv");
    stall_ex = 1; stall_mem = 1; ex_hilo_temp = 64'hCAFE0000BEEF; ex_cnt = 2'd2; ex_wdata = 32'h9999;
    model_step();
    step();
    chk_all("pre_rst_hold");
    #2;
    rst = 1'b1;
    m = cleared();
    #1;
    chk_all("async_rst");
    step();
    chk_all("rst_held");
    rst = 1'b0;
    drive_zero();
    ex_wd = 5'd5; ex_wreg = 1; ex_wdata = 32'hDEADBEEF; ex_aluop = 8'h23; ex_mem_addr = 32'h100;
    model_step();
    step();
    chk_all("post_rst_adv");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
